id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register of the RV32I core, sitting directly upstream of the ALU and driving its `SrcA`, `SrcB` and `Operation` inputs. It latches one decoded instruction per accepted handshake and resolves data hazards by forwarding results from the EX/MEM and MEM/WB stages. Held operands are kept current by refreshing them from the forwarding paths every stall cycle. It supports backpressure from execute and a flush for branch/jump redirects.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR`, 5, register index width

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `rs1_data`, `rs2_data`  in  DATA_WIDTH  register-file read data
- `imm`  in  DATA_WIDTH  sign-extended immediate
- `rs1_addr`, `rs2_addr`, `rd_addr`  in  REG_ADDR  register indices
- `alu_op`  in  OPCODE_LENGTH  ALU operation code
- `alu_src`  in  1  1 = SrcB takes immediate
- `reg_write`  in  1  instruction writes rd
- `flush`  in  1  squash held and incoming instruction
- `exmem_reg_write`, `memwb_reg_write`  in  1  producer write enables
- `exmem_rd`, `memwb_rd`  in  REG_ADDR  producer destinations
- `exmem_result`, `memwb_result`  in  DATA_WIDTH  producer values
- `out_ready`  in  1  execute consumes this cycle
- `out_valid`  out  1  held instruction valid
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU operation
- `store_data`  out  DATA_WIDTH  forwarded rs2 value
- `rd_out`  out  REG_ADDR; `reg_write_out`  out  1

## Operation
- Storage: valid bit, rs1/rs2 data, imm, rs1/rs2/rd addr, alu_op, alu_src, reg_write.
- `in_ready = !out_valid || out_ready` (combinational, independent of `in_valid`).
- Load: `in_valid && in_ready && !flush` → capture all inputs, valid←1.
- Drain: `out_valid && out_ready` with no load → valid←0.
- Hold: `out_valid && !out_ready && !flush` → fields kept, but stored rs1/rs2 data overwritten with their forwarded values (refresh).
- Flush: valid←0 next cycle regardless of other inputs; incoming instruction discarded; data fields don't-care.
- Forwarding function fwd(addr, stored): if `exmem_reg_write && exmem_rd==addr && addr!=0` → `exmem_result`; else if `memwb_reg_write && memwb_rd==addr && addr!=0` → `memwb_result`; else stored. EX/MEM wins on double match.
- Outputs (combinational from state + forwarding inputs): `SrcA = fwd(rs1)`; `store_data = fwd(rs2)`; `SrcB = alu_src ? imm : fwd(rs2)`.
- Bubble: when `out_valid==0`, `Operation = 4'b0000`, `reg_write_out = 0`, `rd_out = 0`; SrcA/SrcB/store_data don't-care.
- Register x0: address 0 never forwards; stored data passed through unchanged.

## Timing
- Reset (`reset==0` at edge): valid←0, all stored fields←0; outputs after reset: `out_valid=0`, `in_ready=1`, `Operation=0`, `reg_write_out=0`, `rd_out=0`, `SrcA=SrcB=store_data=0` (no forwarding match with addr 0).
- Reset dominates load, flush and refresh; reset mid-hold drops the instruction.
- Latency: input accepted at edge N appears on outputs during cycle N+1.
- Throughput: one instruction/cycle when `out_ready=1` (simultaneous drain and load).
- Forwarding is same-cycle combinational; refresh makes a value forwarded in stall cycle k available from storage in cycle k+1 onwards, after the producer retires.
- Flush in same cycle as `in_valid && in_ready`: nothing captured, `out_valid=0` next cycle.

## Test plan
- Reset: hold `reset=0` two cycles with `in_valid=1` → `out_valid=0`, `Operation=0000`, `in_ready=1`; release → first instruction captured next edge.
- Back-to-back: ADD x3=x1+x2 (rs1_data=5, rs2_data=7, alu_op=0010), `out_ready=1` → next cycle `SrcA=5`, `SrcB=7`, `Operation=0010`; new instruction each cycle, no gaps.
- Forward priority: rs1=x4, `exmem_rd=4` result 0x11, `memwb_rd=4` result 0x22 → `SrcA=0x11`; deassert exmem_reg_write → `SrcA=0x22`; rs1=x0 with `exmem_rd=0` → stored value.
- Immediate select: `alu_src=1`, imm=0xFFFFFFFC, rs2 forwarded 9 → `SrcB=0xFFFFFFFC`, `store_data=9`.
- Stall refresh: `out_ready=0`, `exmem_rd=rs1` result 0x55 for one cycle then `exmem_reg_write=0` → `SrcA` stays 0x55; `in_ready=0` throughout stall.
- Flush: held valid instruction with `flush=1` and `in_valid=1` → next cycle `out_valid=0`, `reg_write_out=0`, incoming dropped.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : decode-to-execute pipeline register with operand forwarding
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic [REG_ADDR-1:0]      rs1_addr,
  input  logic [REG_ADDR-1:0]      rs2_addr,
  input  logic [REG_ADDR-1:0]      rd_addr,
  input  logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic                     alu_src,
  input  logic                     reg_write,
  input  logic                     flush,
  input  logic                     exmem_reg_write,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR-1:0]      exmem_rd,
  input  logic [REG_ADDR-1:0]      memwb_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    store_data,
  output logic [REG_ADDR-1:0]      rd_out,
  output logic                     reg_write_out
);

  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_rs1_data;
  logic [DATA_WIDTH-1:0]    r_rs2_data;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic [REG_ADDR-1:0]      r_rs1_addr;
  logic [REG_ADDR-1:0]      r_rs2_addr;
  logic [REG_ADDR-1:0]      r_rd_addr;
  logic [OPCODE_LENGTH-1:0] r_alu_op;
  logic                     r_alu_src;
  logic                     r_reg_write;

  logic                     w_load;
  logic [DATA_WIDTH-1:0]    w_fwd_rs1;
  logic [DATA_WIDTH-1:0]    w_fwd_rs2;

  // EX/MEM has priority over MEM/WB; x0 never forwards.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR-1:0]   addr,
    input logic [DATA_WIDTH-1:0] stored
  );
    if (exmem_reg_write && (exmem_rd == addr) && (addr != '0))
      fwd = exmem_result;
    else if (memwb_reg_write && (memwb_rd == addr) && (addr != '0))
      fwd = memwb_result;
    else
      fwd = stored;
  endfunction

  assign in_ready  = !r_valid || out_ready;
  assign w_load    = in_valid && in_ready && !flush;
  assign w_fwd_rs1 = fwd(r_rs1_addr, r_rs1_data);
  assign w_fwd_rs2 = fwd(r_rs2_addr, r_rs2_data);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_alu_op    <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_rs1_data  <= rs1_data;
      r_rs2_data  <= rs2_data;
      r_imm       <= imm;
      r_rs1_addr  <= rs1_addr;
      r_rs2_addr  <= rs2_addr;
      r_rd_addr   <= rd_addr;
      r_alu_op    <= alu_op;
      r_alu_src   <= alu_src;
      r_reg_write <= reg_write;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      // Stalled: capture forwarded operands so they survive producer retirement.
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end
  end

  assign out_valid     = r_valid;
  assign SrcA          = w_fwd_rs1;
  assign store_data    = w_fwd_rs2;
  assign SrcB          = r_alu_src ? r_imm : w_fwd_rs2;
  assign Operation     = r_valid ? r_alu_op : '0;
  assign rd_out        = r_valid ? r_rd_addr : '0;
  assign reg_write_out = r_valid && r_reg_write;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : scoreboard bench for the ID/EX pipeline register
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_op;
  logic        alu_src, reg_write, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        out_ready, out_valid;
  logic [31:0] SrcA, SrcB, store_data;
  logic [3:0]  Operation;
  logic [4:0]  rd_out;
  logic        reg_write_out;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .out_ready(out_ready), .out_valid(out_valid),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] im, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] rd,
                           input logic [3:0] op, input logic src, input logic rw);
    rs1_data = d1; rs2_data = d2; imm = im;
    rs1_addr = a1; rs2_addr = a2; rd_addr = rd;
    alu_op = op; alu_src = src; reg_write = rw;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    exmem_rd = '0; memwb_rd = '0;
    exmem_result = '0; memwb_result = '0;
  endtask

  task automatic test_reset();
    exp_t e, got;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    clear_fwd();
    set_instr(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 4'b0010, 1'b0, 1'b1);
    tick(); tick();
    checks++;
    if ({out_valid, in_ready, Operation, reg_write_out, rd_out} !== {1'b0, 1'b1, 4'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b rdy=%b op=%h rw=%b rd=%0d expected 0 1 0 0 0",
               out_valid, in_ready, Operation, reg_write_out, rd_out);
    end
    checks++;
    if ({SrcA, SrcB, store_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h expected zeros", SrcA, SrcB, store_data);
    end
    reset = 1'b1;
    q.push_back('{a:32'd5, b:32'd7, op:4'b0010, sd:32'd7, rd:5'd3, rw:1'b1});
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_release_valid: got %b expected 1", out_valid);
    end
    checks++;
    got = {SrcA, SrcB, Operation, store_data, rd_out, reg_write_out};
    if (q.size() == 0) begin
      errors++; $display("FAIL reset_release: scoreboard empty");
    end else begin
      e = q.pop_front();
      if (got !== e) begin
        errors++; $display("FAIL reset_release: got %h expected %h", got, e);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    logic [31:0] d1, d2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    out_ready = 1'b1; in_valid = 1'b1; clear_fwd();
    for (int i = 0; i < 5; i++) begin
      d1 = 32'd5 + i; d2 = 32'd7 + 3 * i; op = 4'(2 + i); rd = 5'(3 + i); rw = (i % 2) == 0;
      set_instr(d1, d2, 32'hABCD0000 + i, 5'd1, 5'd2, rd, op, 1'b0, rw);
      q.push_back('{a:d1, b:d2, op:op, sd:d2, rd:rd, rw:rw});
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b11) begin
        errors++; $display("FAIL b2b_hs[%0d]: got v=%b rdy=%b expected 1 1", i, out_valid, in_ready);
      end
      checks++;
      got = {SrcA, SrcB, Operation, store_data, rd_out, reg_write_out};
      if (q.size() == 0) begin
        errors++; $display("FAIL b2b[%0d]: scoreboard empty", i);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, got, e);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_forward_priority();
    out_ready = 1'b0; in_valid = 1'b1; clear_fwd();
    set_instr(32'h100, 32'h200, 32'd0, 5'd4, 5'd5, 5'd8, 4'b0000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h22;
    #1;
    checks++;
    if (SrcA !== 32'h11) begin
      errors++; $display("FAIL fwd_both: got %h expected 00000011", SrcA);
    end
    exmem_reg_write = 1'b0;
    #1;
    checks++;
    if (SrcA !== 32'h22) begin
      errors++; $display("FAIL fwd_memwb: got %h expected 00000022", SrcA);
    end
    checks++;
    if (store_data !== 32'h200) begin
      errors++; $display("FAIL fwd_nomatch_rs2: got %h expected 00000200", store_data);
    end
    clear_fwd(); out_ready = 1'b1;
    tick();
    in_valid = 1'b1; out_ready = 1'b0;
    set_instr(32'h33, 32'h44, 32'd0, 5'd0, 5'd0, 5'd1, 4'b0001, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
    memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
    #1;
    checks++;
    if ({SrcA, store_data} !== {32'h33, 32'h44}) begin
      errors++; $display("FAIL fwd_x0: got %h %h expected 00000033 00000044", SrcA, store_data);
    end
    clear_fwd(); out_ready = 1'b1;
    tick();
  endtask

  task automatic test_imm_select();
    exp_t e, got;
    out_ready = 1'b1; in_valid = 1'b1; clear_fwd();
    set_instr(32'd3, 32'd1, 32'hFFFFFFFC, 5'd10, 5'd6, 5'd11, 4'b0110, 1'b1, 1'b1);
    memwb_reg_write = 1'b1; memwb_rd = 5'd6; memwb_result = 32'd9;
    q.push_back('{a:32'd3, b:32'hFFFFFFFC, op:4'b0110, sd:32'd9, rd:5'd11, rw:1'b1});
    tick();
    in_valid = 1'b0;
    checks++;
    got = {SrcA, SrcB, Operation, store_data, rd_out, reg_write_out};
    if (q.size() == 0) begin
      errors++; $display("FAIL imm_select: scoreboard empty");
    end else begin
      e = q.pop_front();
      if (got !== e) begin
        errors++; $display("FAIL imm_select: got %h expected %h", got, e);
      end
    end
    clear_fwd();
    tick();
  endtask

  task automatic test_stall_refresh();
    out_ready = 1'b0; in_valid = 1'b1; clear_fwd();
    set_instr(32'h1, 32'h2, 32'd0, 5'd7, 5'd12, 5'd13, 4'b0011, 1'b0, 1'b1);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h55;
    set_instr(32'h99, 32'h98, 32'd0, 5'd14, 5'd15, 5'd16, 4'b1111, 1'b0, 1'b1);
    #1;
    checks++;
    if ({in_ready, SrcA} !== {1'b0, 32'h55}) begin
      errors++; $display("FAIL stall_fwd: got rdy=%b a=%h expected 0 00000055", in_ready, SrcA);
    end
    tick();
    exmem_reg_write = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({out_valid, in_ready, SrcA, Operation, rd_out} !== {1'b1, 1'b0, 32'h55, 4'b0011, 5'd13}) begin
        errors++;
        $display("FAIL stall_refresh[%0d]: got v=%b rdy=%b a=%h op=%h rd=%0d expected 1 0 00000055 3 13",
                 k, out_valid, in_ready, SrcA, Operation, rd_out);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; clear_fwd();
    set_instr(32'h7, 32'h8, 32'd0, 5'd1, 5'd2, 5'd9, 4'b0100, 1'b0, 1'b1);
    tick();
    checks++;
    if ({out_valid, reg_write_out} !== 2'b11) begin
      errors++; $display("FAIL flush_pre: got v=%b rw=%b expected 1 1", out_valid, reg_write_out);
    end
    flush = 1'b1;
    set_instr(32'h17, 32'h18, 32'd0, 5'd3, 5'd4, 5'd20, 4'b0101, 1'b0, 1'b1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, reg_write_out, rd_out, Operation} !== {1'b0, 1'b0, 5'd0, 4'd0}) begin
      errors++;
      $display("FAIL flush_held: got v=%b rw=%b rd=%0d op=%h expected 0 0 0 0",
               out_valid, reg_write_out, rd_out, Operation);
    end
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_incoming: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0; in_valid = 1'b1; clear_fwd();
    set_instr(32'h70, 32'h80, 32'h90, 5'd1, 5'd2, 5'd3, 4'b1000, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, SrcA, SrcB, Operation} !== {1'b0, 32'd0, 32'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_hold: got v=%b a=%h b=%h op=%h expected 0 0 0 0",
               out_valid, SrcA, SrcB, Operation);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_forward_priority();
    test_imm_select();
    test_stall_refresh();
    test_flush();
    test_reset_hold();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
